// File: rtl/aes_ctr_pkg.sv
// Shared types, widths and counter helpers for the AES-CTR block controller.
package aes_ctr_pkg;

  localparam int BLK_W = 128;
  localparam int KEY_W = 256;
  localparam int CTR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Advance the 32-bit counter field; the nonce part is carried unchanged.
  function automatic logic [BLK_W-1:0] ctr_incr(input logic [BLK_W-1:0] blk);
    return {blk[BLK_W-1:CTR_W], blk[CTR_W-1:0] + {{(CTR_W-1){1'b0}}, 1'b1}};
  endfunction

  // True when the next increment rolls the counter field over to zero.
  function automatic logic ctr_at_max(input logic [BLK_W-1:0] blk);
    return &blk[CTR_W-1:0];
  endfunction

endpackage

// File: rtl/aes_ctr_ctrl.sv
// AES-CTR sequencer: feeds counter blocks to an external AES core, XORs the
// keystream onto plaintext and hands out ciphertext, one block in flight.
module aes_ctr_ctrl
  import aes_ctr_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [KEY_W-1:0] cfg_key,
  input  logic [BLK_W-1:0] cfg_iv,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [BLK_W-1:0] din,
  input  logic             din_last,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [BLK_W-1:0] dout,
  output logic             dout_last,
  output logic             core_start,
  output logic [BLK_W-1:0] core_block,
  output logic [KEY_W-1:0] core_key,
  input  logic             core_done,
  input  logic [BLK_W-1:0] core_result,
  output logic             busy,
  output logic             err_timeout,
  output logic             ctr_wrap
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  // Timer value seen in the last permitted WAIT cycle (timer is 0 in the start cycle).
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_t           state;
  state_t           state_next;
  logic [KEY_W-1:0] key_reg;
  logic [BLK_W-1:0] ctr_reg;
  logic [BLK_W-1:0] din_reg;
  logic             last_reg;
  logic [TMR_W-1:0] tmr;

  logic take_cfg;
  logic take_in;
  logic take_done;
  logic time_out;
  logic give_out;

  assign core_block = ctr_reg;
  assign core_key   = key_reg;

  // Next-state decode and single-cycle action strobes.
  always_comb begin
    state_next = state;
    take_cfg   = 1'b0;
    take_in    = 1'b0;
    take_done  = 1'b0;
    time_out   = 1'b0;
    give_out   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_load) begin
          take_cfg   = 1'b1;
          state_next = ST_READY;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_READY: begin
        if (din_valid && din_ready) begin
          take_in    = 1'b1;
          state_next = ST_WAIT;
        end else begin
          state_next = ST_READY;
        end
      end
      ST_WAIT: begin
        // A done pulse coincident with our own start pulse cannot belong to this block.
        if (core_done && !core_start) begin
          take_done  = 1'b1;
          state_next = ST_OUT;
        end else if (tmr == TMR_LAST) begin
          time_out   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_OUT: begin
        if (dout_valid && dout_ready) begin
          give_out   = 1'b1;
          state_next = dout_last ? ST_IDLE : ST_READY;
        end else begin
          state_next = ST_OUT;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Configuration: key and counter block, plus the sticky status flags they reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_reg     <= {KEY_W{1'b0}};
      ctr_reg     <= {BLK_W{1'b0}};
      err_timeout <= 1'b0;
      ctr_wrap    <= 1'b0;
    end else if (take_cfg) begin
      key_reg     <= cfg_key;
      ctr_reg     <= cfg_iv;
      err_timeout <= 1'b0;
      ctr_wrap    <= 1'b0;
    end else if (take_done) begin
      ctr_reg  <= ctr_incr(ctr_reg);
      ctr_wrap <= ctr_wrap | ctr_at_max(ctr_reg);
    end else if (time_out) begin
      err_timeout <= 1'b1;
    end
  end

  // Plaintext capture, core start pulse and core latency timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_reg    <= {BLK_W{1'b0}};
      last_reg   <= 1'b0;
      core_start <= 1'b0;
      tmr        <= {TMR_W{1'b0}};
    end else begin
      core_start <= take_in;
      if (take_in) begin
        din_reg  <= din;
        last_reg <= din_last;
        tmr      <= {TMR_W{1'b0}};
      end else if (state == ST_WAIT) begin
        tmr <= tmr + TMR_W'(1);
      end else begin
        tmr <= tmr;
      end
    end
  end

  // Ciphertext output register; held until the consumer accepts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= {BLK_W{1'b0}};
      dout_last  <= 1'b0;
      dout_valid <= 1'b0;
    end else if (take_done) begin
      dout       <= din_reg ^ core_result;
      dout_last  <= last_reg;
      dout_valid <= 1'b1;
    end else if (give_out) begin
      dout_valid <= 1'b0;
    end
  end

  // Registered status derived from the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      din_ready <= (state_next == ST_READY);
      busy      <= (state_next != ST_IDLE);
    end
  end

endmodule

// File: doc/aes_ctr_ctrl.md
AES_CTR_CTRL -- requirements
Module: aes_ctr_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 64, max cycles from core_start to core_done before abort.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cfg_load  in  1  one-cycle pulse; captures cfg_key and cfg_iv.
- cfg_key  in  256  AES-256 key.
- cfg_iv  in  128  initial counter block: nonce[127:32], counter[31:0].
- din_valid / din_ready  in / out  1  plaintext block handshake.
- din  in  128  plaintext block.
- din_last  in  1  marks final block of message.
- dout_valid / dout_ready  out / in  1  ciphertext block handshake.
- dout  out  128  ciphertext block.
- dout_last  out  1  copy of din_last for this block.
- core_start  out  1  one-cycle pulse to AES core.
- core_block  out  128  counter block to encrypt.
- core_key  out  256  registered key to core.
- core_done  in  1  one-cycle pulse; core_result valid.
- core_result  in  128  AES(core_key, core_block).
- busy  out  1  high in any state except IDLE.
- err_timeout  out  1  sticky; set on core timeout.
- ctr_wrap  out  1  sticky; set when counter[31:0] wraps.

Function
REQ-003 SHALL implement FSM IDLE, READY, WAIT, OUT.
REQ-004 IDLE: cfg_load -> capture key into core_key, iv into ctr_reg, clear err_timeout and ctr_wrap, go READY next cycle.
REQ-005 cfg_load outside IDLE SHALL be ignored.
REQ-006 READY: din_ready=1; din_valid&din_ready -> register din and din_last, go WAIT; core_start=1 for exactly the first WAIT cycle with core_block=ctr_reg.
REQ-007 din_ready SHALL be 0 in IDLE, WAIT and OUT; one block in flight max.
REQ-008 WAIT: core_done -> dout=din_reg XOR core_result, dout_valid=1 next cycle, go OUT.
REQ-009 Counter update on core_done: ctr_reg[31:0] += 1 mod 2^32; ctr_reg[127:32] unchanged; 0xFFFFFFFF->0 sets ctr_wrap.
REQ-010 core_done in any state but WAIT, or in the core_start cycle, SHALL be ignored.
REQ-011 WAIT SHALL count cycles from core_start; count reaching TIMEOUT_CYC without core_done -> err_timeout=1, discard block, go IDLE.
REQ-012 OUT: dout, dout_last, dout_valid stable until dout_ready; dout_valid&dout_ready -> go READY, or IDLE if dout_last.
REQ-013 dout_ready high on OUT entry SHALL complete transfer that cycle; min throughput one block per (core latency + 3) cycles.
REQ-014 core_block SHALL equal ctr_reg at all times; core_key SHALL hold captured key until next cfg_load.
REQ-015 busy SHALL be 1 in READY, WAIT, OUT.

Reset
REQ-016 rst low SHALL asynchronously force IDLE; clear key, ctr_reg, din_reg, timeout count.
REQ-017 Reset values: din_ready, dout_valid, dout_last, core_start, busy, err_timeout, ctr_wrap = 0; dout, core_block, core_key = 0.
REQ-018 Reset during WAIT/OUT SHALL drop the in-flight block; a later core_done SHALL be ignored.

Structure
REQ-019 State encoding, block/key widths (128, 256) and counter width (32) SHALL live in shared package aes_ctr_pkg.
REQ-020 SHALL be one module; AES core is external (encryptiontop-style) and connected at the integrating top, not instantiated here.

Verification (bench uses behavioural core model, fixed latency 14 cycles, result = block XOR key[127:0] unless stated)
REQ-021 cfg_load key=0, iv=0x...0000_0001; din=0xffeeddccbbaa99887766554433221100, din_last=1 -> one dout = din XOR 0x...01, dout_last=1, busy=0 after handshake.
REQ-022 iv counter=0xFFFFFFFE, 3 blocks -> core_block low words FFFFFFFE, FFFFFFFF, 00000000; ctr_wrap=1 after 2nd core_done; upper 96 bits unchanged.
REQ-023 dout_ready held low 20 cycles in OUT -> dout stable, din_ready=0, no core_start.
REQ-024 core model never returns done -> err_timeout=1 exactly TIMEOUT_CYC cycles after core_start, state IDLE; next cfg_load clears it.
REQ-025 rst low mid-WAIT, core_done arrives after release -> no dout_valid, outputs at reset values.
REQ-026 Real AES-256 core, key 000102..1f, iv 00112233445566778899aabbccddeeff, din=0 -> dout=8ea2b7ca516745bfeafc49904b496089.
